// File: rtl/rv_div_pkg.sv
// Shared definitions for the RV64M iterative divider: operation encodings,
// controller states and iteration counts.
package rv_div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int N64   = 64;
  localparam int N32   = 32;
  localparam int CNT_W = $clog2(N64);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and keep the trial subtraction when it does not borrow.
module rv_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qBit
);

  logic [XLEN-1:0] w_low;
  logic [XLEN-1:0] w_diff;
  logic            w_carry;

  // Trial subtract as add of the inverted divisor with carry-in 1; a set top
  // remainder bit means the shifted value already exceeds any divisor.
  always_comb begin
    w_low             = {i_rem[XLEN-2:0], i_bit};
    {w_carry, w_diff} = {1'b0, w_low} + {1'b0, ~i_divisor} + {{XLEN{1'b0}}, 1'b1};
    o_qBit            = i_rem[XLEN-1] | w_carry;
    o_rem             = o_qBit ? w_diff : w_low;
  end

endmodule

// File: rtl/rv_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their W forms,
// one quotient bit per cycle with a start/busy/done handshake.
module rv_divider
  import rv_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic [XLEN-1:0]  r_result;
  logic             r_selRem;
  logic             r_word;
  logic             r_signQ;
  logic             r_signR;

  logic             w_isSigned;
  logic             w_aNeg;
  logic             w_bNeg;
  logic             w_divZero;
  logic             w_overflow;
  logic             w_special;
  logic             w_accept;
  logic             w_stepQ;
  logic [XLEN-1:0]  w_aExt;
  logic [XLEN-1:0]  w_bExt;
  logic [XLEN-1:0]  w_aAbs;
  logic [XLEN-1:0]  w_bAbs;
  logic [XLEN-1:0]  w_aLoad;
  logic [XLEN-1:0]  w_specialRaw;
  logic [XLEN-1:0]  w_specialRes;
  logic [XLEN-1:0]  w_stepRem;
  logic [XLEN-1:0]  w_quoFinal;
  logic [XLEN-1:0]  w_quoSigned;
  logic [XLEN-1:0]  w_remSigned;
  logic [XLEN-1:0]  w_finalRaw;
  logic [XLEN-1:0]  w_finalRes;

  rv_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[XLEN-1]),
    .i_divisor(r_div),
    .o_rem    (w_stepRem),
    .o_qBit   (w_stepQ)
  );

  // Operand preparation at accept: width/sign extension, magnitudes and the
  // divide-by-zero / signed-overflow shortcuts that skip the iteration loop.
  always_comb begin
    w_isSigned = ~op[0];
    if (word) begin
      w_aExt = {{(XLEN-32){w_isSigned & dividend[31]}}, dividend[31:0]};
      w_bExt = {{(XLEN-32){w_isSigned & divisor[31]}}, divisor[31:0]};
    end else begin
      w_aExt = dividend;
      w_bExt = divisor;
    end
    w_aNeg  = w_isSigned & w_aExt[XLEN-1];
    w_bNeg  = w_isSigned & w_bExt[XLEN-1];
    w_aAbs  = w_aNeg ? -w_aExt : w_aExt;
    w_bAbs  = w_bNeg ? -w_bExt : w_bExt;
    // W forms park the 32-bit dividend at the top so 32 shifts consume it.
    w_aLoad = word ? {w_aAbs[31:0], {(XLEN-32){1'b0}}} : w_aAbs;

    w_divZero  = (w_bExt == '0);
    w_overflow = w_isSigned & (w_bExt == '1) &
                 (word ? (dividend[31:0] == 32'h8000_0000) : (dividend == MIN_NEG));
    w_special  = w_divZero | w_overflow;
    w_accept   = start & (r_state != ST_CALC);

    if (op[1]) begin
      w_specialRaw = w_divZero ? dividend : '0;
    end else begin
      w_specialRaw = w_divZero ? '1 : dividend;
    end
    w_specialRes = word ? {{(XLEN-32){w_specialRaw[31]}}, w_specialRaw[31:0]} : w_specialRaw;
  end

  // Final correction on the last iteration: restore signs, pick quotient or
  // remainder, and sign-extend bit 31 for W forms.
  always_comb begin
    w_quoFinal  = {r_quo[XLEN-2:0], w_stepQ};
    w_quoSigned = r_signQ ? -w_quoFinal : w_quoFinal;
    w_remSigned = r_signR ? -w_stepRem : w_stepRem;
    w_finalRaw  = r_selRem ? w_remSigned : w_quoSigned;
    w_finalRes  = r_word ? {{(XLEN-32){w_finalRaw[31]}}, w_finalRaw[31:0]} : w_finalRaw;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake outputs; DONE can accept a new request directly.
  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_stateNext = w_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (r_count == '0) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_stateNext = w_special ? ST_DONE : ST_CALC;
        end else begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate while calculating, and
  // register the result on entry to DONE so it holds until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_selRem <= 1'b0;
      r_word   <= 1'b0;
      r_signQ  <= 1'b0;
      r_signR  <= 1'b0;
    end else if (w_accept) begin
      r_selRem <= op[1];
      r_word   <= word;
      r_signQ  <= w_aNeg ^ w_bNeg;
      r_signR  <= w_aNeg;
      r_rem    <= '0;
      r_quo    <= w_aLoad;
      r_div    <= w_bAbs;
      r_count  <= word ? CNT_W'(N32 - 1) : CNT_W'(N64 - 1);
      if (w_special) begin
        r_result <= w_specialRes;
      end
    end else if (r_state == ST_CALC) begin
      r_rem   <= w_stepRem;
      r_quo   <= {r_quo[XLEN-2:0], w_stepQ};
      r_count <= r_count - 1'b1;
      if (r_count == '0) begin
        r_result <= w_finalRes;
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_rv_divider.sv
// Self-checking bench for rv_divider: an arithmetic reference model with a
// latency model, a per-cycle compare process, directed literal cases and a
// randomized phase.
module tb_rv_divider;
  import rv_div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic        word;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  // Reference model state: age counts cycles since the accepting edge.
  logic        mActive;
  int          mAge;
  int          mLat;
  logic [63:0] mPend;
  logic [63:0] mResult;

  rv_divider #(.XLEN(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .word    (word),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural result of an RV64M divide/remainder instruction.
  function automatic logic [63:0] refResult(input logic [1:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sa32, sb32;
    int unsigned     ua32, ub32;
    logic [31:0]     r32;
    logic [63:0]     r;
    r   = '0;
    r32 = '0;
    if (!w) begin
      sa = a; sb = b; ua = a; ub = b;
      case (o)
        OP_DIV: begin
          if (b == 0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else r = sa / sb;
        end
        OP_DIVU: begin
          if (b == 0) r = '1;
          else r = ua / ub;
        end
        OP_REM: begin
          if (b == 0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else r = sa % sb;
        end
        default: begin
          if (b == 0) r = a;
          else r = ua % ub;
        end
      endcase
    end else begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      case (o)
        OP_DIV: begin
          if (b[31:0] == 0) r32 = '1;
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = a[31:0];
          else r32 = sa32 / sb32;
        end
        OP_DIVU: begin
          if (b[31:0] == 0) r32 = '1;
          else r32 = ua32 / ub32;
        end
        OP_REM: begin
          if (b[31:0] == 0) r32 = a[31:0];
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = '0;
          else r32 = sa32 % sb32;
        end
        default: begin
          if (b[31:0] == 0) r32 = a[31:0];
          else r32 = ua32 % ub32;
        end
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic logic isSpecial(input logic [1:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 0) || (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [63:0] genOperand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 40));
      5: return -64'($urandom_range(1, 40));
      6: return {32'h0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic w,
                               input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    word     = w;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int first, output int lat);
    lat = first;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runCheck(input string name, input logic [1:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] want, input int wantLat);
    int lat;
    applyStimulus(o, w, a, b);
    waitDone(1, lat);
    checkOutput({name, "_lat"}, 64'(lat), 64'(wantLat));
    checkOutput({name, "_res"}, result, want);
  endtask

  // Cycle model: accepts whenever not busy, done appears lat cycles later.
  initial begin
    mActive = 1'b0;
    mAge    = 0;
    mLat    = 1;
    mPend   = '0;
    mResult = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mActive = 1'b0;
        mAge    = 0;
        mResult = '0;
      end else begin
        if (start && !(mActive && mAge < mLat)) begin
          mActive = 1'b1;
          mAge    = 1;
          mLat    = isSpecial(op, word, dividend, divisor) ? 1 : (word ? 33 : 65);
          mPend   = refResult(op, word, dividend, divisor);
        end else if (mActive) begin
          mAge++;
        end
        if (mActive && mAge == mLat) mResult = mPend;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("busy", 64'(busy), 64'(mActive && mAge < mLat));
      checkOutput("done", 64'(done), 64'(mActive && mAge == mLat));
      checkOutput("result", result, mResult);
    end
  end

  initial begin
    int lat;
    rst_n    = 1'b1;
    start    = 1'b0;
    op       = OP_DIV;
    word     = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runCheck("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    runCheck("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    runCheck("rem_m7_2",   OP_REM,  1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    runCheck("div_m7_2",   OP_DIV,  1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    runCheck("div_5_0",    OP_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    runCheck("remu_5_0",   OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    runCheck("div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1);
    runCheck("rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 1);
    runCheck("divw_min_1", OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'd1,
             64'hFFFF_FFFF_8000_0000, 33);
    runCheck("divuw_ff_2", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
             64'h0000_0000_7FFF_FFFF, 33);
    runCheck("remw_m7_2",  OP_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Abort an operation with reset mid-way.
    applyStimulus(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // New operation after reset, with a start pulse while busy that must be ignored.
    applyStimulus(OP_DIVU, 1'b0, 64'd9, 64'd3);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    op       = OP_DIV;
    dividend = 64'd77;
    divisor  = 64'd5;
    @(negedge clk);
    start = 1'b0;
    waitDone(6, lat);
    checkOutput("post_reset_lat", 64'(lat), 64'd65);
    checkOutput("post_reset_res", result, 64'd3);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 3) == 0);
      op       = 2'($urandom_range(0, 3));
      word     = 1'($urandom_range(0, 1));
      dividend = genOperand();
      divisor  = genOperand();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (70) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_divider.md
Name: rv_divider

Overview:
Iterative restoring divider for the RV64M divide/remainder group: DIV, DIVU, REM, REMU and their 32-bit W forms. It is the inverse-direction companion of the adder datapath, computing quotient/remainder one bit per cycle by trial subtraction. It sits beside the multiplier in the execute stage, with a start/busy/done handshake towards the pipeline control.

Parameters:
XLEN, 64, datapath width; W forms operate on the low 32 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
word  input  1  1 = W form (DIVW/DIVUW/REMW/REMUW)
dividend  input  XLEN  rs1 value
divisor  input  XLEN  rs2 value
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
result  output  XLEN  quotient or remainder; held until next accepted start

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, busy=0, done=0, result=0, all internal registers 0. Reset mid-operation aborts with no done pulse.
- States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE directly for special cases.
- Accept: start=1 and state IDLE (or DONE) -> latch op, word and operands; busy=1 next cycle. start while busy=1 is ignored.
- Operand prep, at accept: signed ops (op[0]=0) take absolute values and record sign_q = sign(a) xor sign(b) and sign_r = sign(a). For W forms, use the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
- CALC: N iterations (N=64, or 32 if word=1). Each cycle: shift {rem,quo} left by 1; trial = rem - divisor, done as an add of the inverted divisor with carry-in 1. If there is no borrow, rem = trial and quotient bit = 1; otherwise quotient bit = 0. An iteration counter counts down from N-1.
- DONE (one cycle): negate the quotient if sign_q, negate the remainder if sign_r (signed ops only). Select the quotient for op[1]=0 and the remainder for op[1]=1. For W forms, sign-extend bit 31 to XLEN regardless of signedness. Register result, done=1, busy=0.
- Latency: start accepted at cycle 0; done=1 at cycle N+1 (65 normal, 33 word).
- Special cases, detected at accept; state goes straight to DONE, done at cycle 1:
  - divisor==0: quotient = all ones; remainder = dividend (W forms: low 32 bits, sign-extended).
  - Signed overflow, dividend = most negative (64- or 32-bit) and divisor = -1: quotient = dividend; remainder = 0.
- start asserted in the same cycle as done: accepted; the new operation begins; result holds until the new done.
- busy is high from the cycle after accept through the cycle before done.

Decomposition:
- rv_div_pkg: op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), state enum (ST_IDLE, ST_CALC, ST_DONE), iteration counts (N64=64, N32=32).
- Sub-module rv_div_step: combinational single iteration. Inputs are the partial remainder, next dividend bit and divisor; outputs are the new remainder and quotient bit. One instance, used by the iterating FSM.

Test Plan:
- DIVU 100 / 7 -> result 14 at cycle 65; REMU same operands -> 2; busy high cycles 1-64.
- REM -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIV -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFD (-3).
- DIV 5 / 0 -> 0xFFFF_FFFF_FFFF_FFFF at cycle 1; REMU 5 / 0 -> 5.
- DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000 at cycle 1; REM -> 0.
- DIVW 0x0000_0000_8000_0000 / 1 -> 0xFFFF_FFFF_8000_0000 at cycle 33; DIVUW 0xFFFF_FFFF / 2 -> 0x0000_0000_7FFF_FFFF.
- DIVU 100/7 started, rst_n low at cycle 10 -> busy=0, done=0, result=0 immediately. After release, DIVU 9/3 -> result 3 at cycle 65 with no stale done pulse; start pulses while busy are ignored.
